// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op-field layout, access-size
// codes, FSM state encoding and the default datapath width.
package lsu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   // req_op layout: [3] store, [2] unsigned load, [1:0] access size
   localparam int OP_STORE = 3;
   localparam int OP_UNS   = 2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_DONE   = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering shared by the store and load paths.
// Ports:
//   i_size     access size code (byte/half/word, 11 reserved)
//   i_uns      zero-extend loads instead of sign-extending
//   i_offs     byte offset within the word (addr[1:0])
//   i_wdata    right-aligned store data
//   i_rdata    raw read word from memory
//   o_strb     byte-lane write enables for the store
//   o_wdata    store data moved into its byte lanes
//   o_misalign access violates natural alignment or uses the reserved size
//   o_rdata    selected and extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]            i_size,
   input  logic                  i_uns,
   input  logic [1:0]            i_offs,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [3:0]            o_strb,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_misalign,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [4:0]            w_shamt;
   logic [DATA_WIDTH-1:0] w_lane;

   assign w_shamt = {i_offs, 3'b000};
   assign w_lane  = i_rdata >> w_shamt;

   always_comb begin
      o_strb     = 4'b0000;
      o_misalign = 1'b0;
      o_wdata    = i_wdata << w_shamt;
      case (i_size)
         SZ_BYTE: o_strb = 4'b0001 << i_offs;
         SZ_HALF: begin
            o_strb     = 4'b0011 << i_offs;
            o_misalign = i_offs[0];
         end
         SZ_WORD: begin
            o_strb     = 4'b1111;
            o_misalign = |i_offs;
         end
         default: o_misalign = 1'b1;
      endcase
   end

   always_comb begin
      o_rdata = w_lane;
      case (i_size)
         SZ_BYTE: o_rdata = {{24{~i_uns & w_lane[7]}},  w_lane[7:0]};
         SZ_HALF: o_rdata = {{16{~i_uns & w_lane[15]}}, w_lane[15:0]};
         default: o_rdata = w_lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes one memory op from the controller, runs a single
// valid/ready memory transaction and returns an extended load result or a
// store completion as a one-cycle response pulse.
//
//   state  | meaning
//   IDLE   | ready for an op; misaligned ops skip straight to DONE
//   REQ    | memory request presented, waiting for mem_req_ready
//   RDWAIT | load issued, waiting for mem_rdata_valid
//   DONE   | one-cycle response pulse, then back to IDLE
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           op handshake from the controller
//   req_op, req_addr, req_wdata   op code, byte address, right-aligned store data
//   mem_addr, mem_wdata, mem_strb word address, lane-shifted data, lane enables
//   mem_write                     request is a store
//   mem_req_valid/mem_req_ready   memory request handshake
//   mem_rdata, mem_rdata_valid/mem_rdata_ready  read-data handshake
//   resp_valid, resp_data, resp_err             completion pulse and result
module lsu #(
   parameter int DATA_WIDTH = lsu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = lsu_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_strb,
   output logic                  mem_write,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rdata_valid,
   output logic                  mem_rdata_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_err
);
   import lsu_pkg::*;

   lsu_state_e            r_state;
   lsu_state_e            w_state_nxt;
   logic [3:0]            r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_resp_data;
   logic                  r_err;

   logic [1:0]            w_size;
   logic [1:0]            w_offs;
   logic [3:0]            w_strb;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_misalign;
   logic [DATA_WIDTH-1:0] w_load_data;

   // The aligner sees the incoming op while idle (to flag misalignment at
   // accept time) and the latched op for the rest of the transaction.
   assign w_size = (r_state == ST_IDLE) ? req_op[1:0]   : r_op[1:0];
   assign w_offs = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr[1:0];

   lsu_align u_align (
      .i_size     (w_size),
      .i_uns      (r_op[OP_UNS]),
      .i_offs     (w_offs),
      .i_wdata    (r_wdata),
      .i_rdata    (mem_rdata),
      .o_strb     (w_strb),
      .o_wdata    (w_wdata),
      .o_misalign (w_misalign),
      .o_rdata    (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_resp_data <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && req_valid) begin
            r_op        <= req_op;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_resp_data <= '0;
            r_err       <= w_misalign;
         end
         if (r_state == ST_RDWAIT && mem_rdata_valid) begin
            r_resp_data <= w_load_data;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      req_ready       = 1'b0;
      mem_req_valid   = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      mem_strb        = 4'b0000;
      mem_write       = 1'b0;
      mem_rdata_ready = 1'b0;
      resp_valid      = 1'b0;
      resp_data       = '0;
      resp_err        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_write     = r_op[OP_STORE];
            if (r_op[OP_STORE]) begin
               mem_strb  = w_strb;
               mem_wdata = w_wdata;
            end
            if (mem_req_ready) begin
               w_state_nxt = r_op[OP_STORE] ? ST_DONE : ST_RDWAIT;
            end
         end
         ST_RDWAIT: begin
            mem_rdata_ready = 1'b1;
            if (mem_rdata_valid) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            resp_valid  = 1'b1;
            resp_data   = r_resp_data;
            resp_err    = r_err;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
